// File: rtl/he_lb_csr_regs.sv
// CSR block for the loopback host exerciser: register file, start/stop
// FSM, saturating status counters and a sticky error flag.
module he_lb_csr_regs #(
  parameter logic [63:0] DFH_VALUE  = 64'h1000_0000_0000_0001,
  parameter logic [63:0] ID_L_VALUE = 64'h0,
  parameter logic [63:0] ID_H_VALUE = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_wr,
  input  logic        csr_rd,
  input  logic [15:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  input  logic        rd_done,
  input  logic        wr_done,
  input  logic        err_in,
  input  logic        test_done,
  output logic        start_pulse,
  output logic        soft_rst_n,
  output logic        running,
  output logic [63:0] src_addr,
  output logic [63:0] dst_addr,
  output logic [63:0] dsm_base,
  output logic [31:0] num_lines,
  output logic [31:0] cfg,
  output logic [31:0] inact_thresh,
  output logic [31:0] stride
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] scratch [3];
  logic [31:0] ctl;
  logic [31:0] rd_cnt, wr_cnt, cyc_cnt;
  logic        err_q;
  logic [31:0] rd_mux;
  logic        ctl_wr, go, cnt_clr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign ctl_wr     = csr_wr && (csr_addr == 16'h138);
  assign go         = (state_q == IDLE) && ctl_wr && csr_wdata[1] && csr_wdata[0] && ctl[0];
  assign cnt_clr    = go || !ctl[0];
  assign soft_rst_n = ctl[0];
  assign running    = (state_q == RUN);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN:  if (test_done || (ctl_wr && csr_wdata[2]) || !ctl[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux samples current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = 32'h0;
    case (csr_addr)
      16'h000: rd_mux = DFH_VALUE[31:0];
      16'h004: rd_mux = DFH_VALUE[63:32];
      16'h008: rd_mux = ID_L_VALUE[31:0];
      16'h00C: rd_mux = ID_L_VALUE[63:32];
      16'h010: rd_mux = ID_H_VALUE[31:0];
      16'h014: rd_mux = ID_H_VALUE[63:32];
      16'h100: rd_mux = scratch[0];
      16'h104: rd_mux = scratch[1];
      16'h108: rd_mux = scratch[2];
      16'h110: rd_mux = dsm_base[31:0];
      16'h114: rd_mux = dsm_base[63:32];
      16'h120: rd_mux = src_addr[31:0];
      16'h124: rd_mux = src_addr[63:32];
      16'h128: rd_mux = dst_addr[31:0];
      16'h12C: rd_mux = dst_addr[63:32];
      16'h130: rd_mux = num_lines;
      16'h138: rd_mux = ctl;
      16'h140: rd_mux = cfg;
      16'h148: rd_mux = inact_thresh;
      16'h160: rd_mux = rd_cnt;
      16'h164: rd_mux = wr_cnt;
      16'h168: rd_mux = cyc_cnt;
      16'h170: rd_mux = {31'h0, err_q};
      16'h178: rd_mux = stride;
      default: rd_mux = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_pulse  <= 1'b0;
      csr_rvalid   <= 1'b0;
      csr_rdata    <= 32'h0;
      scratch[0]   <= 32'h0;
      scratch[1]   <= 32'h0;
      scratch[2]   <= 32'h0;
      ctl          <= 32'h1;
      dsm_base     <= 64'h0;
      src_addr     <= 64'h0;
      dst_addr     <= 64'h0;
      num_lines    <= 32'h0;
      cfg          <= 32'h0;
      inact_thresh <= 32'h0;
      stride       <= 32'h0;
      rd_cnt       <= 32'h0;
      wr_cnt       <= 32'h0;
      cyc_cnt      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_pulse <= go;
      csr_rvalid  <= csr_rd;
      csr_rdata   <= csr_rd ? rd_mux : 32'h0;

      if (csr_wr) begin
        case (csr_addr)
          16'h100: scratch[0]          <= csr_wdata;
          16'h104: scratch[1]          <= csr_wdata;
          16'h108: scratch[2]          <= csr_wdata;
          16'h110: dsm_base[31:0]      <= csr_wdata;
          16'h114: dsm_base[63:32]     <= csr_wdata;
          16'h120: src_addr[31:0]      <= csr_wdata;
          16'h124: src_addr[63:32]     <= csr_wdata;
          16'h128: dst_addr[31:0]      <= csr_wdata;
          16'h12C: dst_addr[63:32]     <= csr_wdata;
          16'h130: num_lines           <= csr_wdata;
          16'h138: ctl                 <= {csr_wdata[31:3], 2'b00, csr_wdata[0]};
          16'h140: cfg                 <= csr_wdata;
          16'h148: inact_thresh        <= csr_wdata;
          16'h178: stride              <= csr_wdata;
          default: ;
        endcase
      end

      if (cnt_clr) begin
        rd_cnt  <= 32'h0;
        wr_cnt  <= 32'h0;
        cyc_cnt <= 32'h0;
      end else begin
        if (rd_done)          rd_cnt  <= sat_inc(rd_cnt);
        if (wr_done)          wr_cnt  <= sat_inc(wr_cnt);
        if (state_q == RUN)   cyc_cnt <= sat_inc(cyc_cnt);
      end

      if (err_in)
        err_q <= 1'b1;
      else if (csr_wr && (csr_addr == 16'h170) && csr_wdata[0])
        err_q <= 1'b0;
    end
  end

endmodule
